// File: rtl/ddr_instr_pkg.sv
// Shared definitions for the DDR4 merged-word format: command codes, slot
// geometry and the bit offsets of each slot field.
package ddr_instr_pkg;

  localparam int SLOT_W    = 32;
  localparam int NUM_SLOTS = 4;

  // Command type codes as carried in slot bits [2:0].
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_PRE = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;
  localparam logic [2:0] CMD_ZQ  = 3'd6;
  localparam logic [2:0] CMD_INV = 3'd7;

  // Field offsets inside one 32-bit slot. Bits [31:24] are always zero.
  localparam int TYPE_LSB  = 0;
  localparam int BANK_LSB  = 3;
  localparam int BG_LSB    = 5;
  localparam int FIELD_LSB = 7;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/instr_slot_encode.sv
// Combinational encoder: one DDR4 command's fields -> one 32-bit slot.
// Must stay bit-exact with the downstream command decoder.
module instr_slot_encode
  import ddr_instr_pkg::*;
#(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 10,
  parameter int ROW_WIDTH  = 17
) (
  input  logic [2:0]            cmd_type,
  input  logic [BG_WIDTH-1:0]   cmd_bg,
  input  logic [BANK_WIDTH-1:0] cmd_bank,
  input  logic [ROW_WIDTH-1:0]  cmd_row,
  input  logic [COL_WIDTH-1:0]  cmd_col,
  input  logic                  cmd_pall,
  output slot_t                 slot
);

  // Build the slot; type 7 is not a real command and encodes as an all-zero NOP.
  always_comb begin
    slot = '0;
    if (cmd_type != CMD_INV) begin
      slot[TYPE_LSB +: 3]          = cmd_type;
      slot[BANK_LSB +: BANK_WIDTH] = cmd_bank;
      slot[BG_LSB +: BG_WIDTH]     = cmd_bg;
    end
    case (cmd_type)
      CMD_ACT:        slot[FIELD_LSB +: ROW_WIDTH] = cmd_row;
      CMD_RD, CMD_WR: slot[FIELD_LSB +: COL_WIDTH] = cmd_col;
      CMD_PRE:        slot[FIELD_LSB]              = cmd_pall;
      default:        ;
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Packs single DDR4 commands into 640-bit merged words: four 32-bit slots in
// [127:0] and one burst of write data in [639:128].
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never depends on ready, and the payload on a valid port is
// held until the transfer. Here cmd_ready may depend on cmd_valid/cmd_type
// (a second WR must seal the current word first).
module instr_packer
  import ddr_instr_pkg::*;
#(
  parameter int          BG_WIDTH     = 2,
  parameter int          BANK_WIDTH   = 2,
  parameter int          COL_WIDTH    = 10,
  parameter int          ROW_WIDTH    = 17,
  parameter int          INSTR_WIDTH  = 128,
  parameter int          WDATA_WIDTH  = 512,
  parameter int          MERGED_WIDTH = 640,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_type,
  input  logic [BG_WIDTH-1:0]     cmd_bg,
  input  logic [BANK_WIDTH-1:0]   cmd_bank,
  input  logic [ROW_WIDTH-1:0]    cmd_row,
  input  logic [COL_WIDTH-1:0]    cmd_col,
  input  logic                    cmd_pall,
  input  logic [WDATA_WIDTH-1:0]  cmd_wdata,
  input  logic                    flush,
  output logic [MERGED_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Accumulator and output register state.
  slot_t [NUM_SLOTS-1:0]   slots_q, slots_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [WDATA_WIDTH-1:0]  acc_wdata_q, acc_wdata_d;
  logic                    has_wr_q, has_wr_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic [MERGED_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  slot_t      slot_enc;
  logic       out_free;
  logic       wr_conflict;
  logic       timeout_hit;
  logic       seal_req;
  logic       transfer;
  logic       accept;
  logic [2:0] cnt_base;

  instr_slot_encode #(
    .BG_WIDTH   (BG_WIDTH),
    .BANK_WIDTH (BANK_WIDTH),
    .COL_WIDTH  (COL_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH)
  ) u_enc (
    .cmd_type (cmd_type),
    .cmd_bg   (cmd_bg),
    .cmd_bank (cmd_bank),
    .cmd_row  (cmd_row),
    .cmd_col  (cmd_col),
    .cmd_pall (cmd_pall),
    .slot     (slot_enc)
  );

  // Seal decision and command handshake; a word holds at most one WR burst.
  always_comb begin
    out_free    = !out_valid_q || out_ready;
    wr_conflict = cmd_valid && (cmd_type == CMD_WR) && has_wr_q;
    timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_W'(TIMEOUT));
    seal_req    = (cnt_q != 3'd0) &&
                  ((cnt_q == 3'(NUM_SLOTS)) || flush || timeout_hit || wr_conflict);
    transfer    = seal_req && out_free;
    cmd_ready   = transfer || ((cnt_q < 3'(NUM_SLOTS)) && !wr_conflict);
    accept      = cmd_valid && cmd_ready;
  end

  // Next accumulator: clear on transfer, then drop an accepted command into the next slot.
  always_comb begin
    slots_d     = transfer ? '0 : slots_q;
    cnt_base    = transfer ? 3'd0 : cnt_q;
    acc_wdata_d = transfer ? '0 : acc_wdata_q;
    has_wr_d    = transfer ? 1'b0 : has_wr_q;
    cnt_d       = cnt_base;
    if (accept) begin
      slots_d[cnt_base[1:0]] = slot_enc;
      cnt_d                  = cnt_base + 3'd1;
      if (cmd_type == CMD_WR) begin
        has_wr_d    = 1'b1;
        acc_wdata_d = cmd_wdata;
      end
    end
  end

  // Idle counter: restarts on any accept or when the accumulator is (or becomes) empty.
  always_comb begin
    idle_d = idle_q;
    if (accept || transfer || (cnt_q == 3'd0)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Output register: load on transfer, drop valid once consumed, otherwise hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (transfer) begin
      out_data_d  = {acc_wdata_q, slots_q};
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards partial and pending words.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q     <= '0;
      cnt_q       <= '0;
      acc_wdata_q <= '0;
      has_wr_q    <= 1'b0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      slots_q     <= slots_d;
      cnt_q       <= cnt_d;
      acc_wdata_q <= acc_wdata_d;
      has_wr_q    <= has_wr_d;
      idle_q      <= idle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != 3'd0) || out_valid_q;

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: a table of single-command encodings, then
// hand-written sequences for packing, WR conflict, timeout, backpressure,
// flush and reset.
module tb_instr_packer;

  localparam int MW = 640;
  localparam int WW = 512;

  typedef struct {
    logic [2:0]  typ;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [16:0] row;
    logic [9:0]  col;
    logic        pall;
    logic [31:0] exp_slot;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_type;
  logic [1:0]    cmd_bg;
  logic [1:0]    cmd_bank;
  logic [16:0]   cmd_row;
  logic [9:0]    cmd_col;
  logic          cmd_pall;
  logic [WW-1:0] cmd_wdata;
  logic          flush;
  logic [MW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  instr_packer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_pall  (cmd_pall),
    .cmd_wdata (cmd_wdata),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] got_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int rise_cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Words are collected mid-cycle, when valid && ready will transfer at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
  end

  function automatic logic [MW-1:0] mk_word(input logic [31:0] s0, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [31:0] s3,
                                            input logic [WW-1:0] wd);
    return {wd, s3, s2, s1, s0};
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: slots got %h expected %h, wdata[63:0] got %h expected %h",
               name, got[127:0], exp[127:0], got[191:128], exp[191:128]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command until accepted (bounded); waited = edges spent offering it.
  task automatic send_cmd(input logic [2:0] t, input logic [1:0] bg, input logic [1:0] bank,
                          input logic [16:0] row, input logic [9:0] col, input logic pall,
                          input logic [WW-1:0] wd, output int waited);
    logic acc;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_bg    = bg;
    cmd_bank  = bank;
    cmd_row   = row;
    cmd_col   = col;
    cmd_pall  = pall;
    cmd_wdata = wd;
    do begin
      #1;
      acc = cmd_ready;
      step();
      n++;
    end while (!acc && n < 200);
    cmd_valid = 1'b0;
    waited = n;
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_cmd: cmd_ready stayed 0 for %0d cycles, expected 1", n);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Compare every queued expectation against collected words, in order.
  task automatic expect_words(input string name);
    while (exp_q.size() > 0) begin
      logic [MW-1:0] e;
      logic [MW-1:0] g;
      int n;
      e = exp_q.pop_front();
      n = 0;
      while (got_q.size() == 0 && n < 100) begin
        step();
        n++;
      end
      if (got_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s: no word within 100 cycles, expected slots %h", name, e[127:0]);
      end else begin
        g = got_q.pop_front();
        check_word(name, g, e);
      end
    end
  endtask

  task automatic expect_no_word(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) step();
    check_int(name, got_q.size(), 0);
    got_q.delete();
  endtask

  // ---------------- test ----------------
  vec_t tbl[11];
  logic [WW-1:0] wa, wb, wt;
  logic [MW-1:0] w1;
  int waited;
  int e_edge;

  initial begin
    tbl[0]  = '{3'd2, 2'd1, 2'd2, 17'h1ABCD, 10'h000, 1'b0, 32'h00D5E6B2}; // ACT
    tbl[1]  = '{3'd3, 2'd0, 2'd0, 17'h00000, 10'h03F, 1'b0, 32'h00001F83}; // RD
    tbl[2]  = '{3'd1, 2'd0, 2'd0, 17'h00000, 10'h000, 1'b1, 32'h00000081}; // PRE all
    tbl[3]  = '{3'd0, 2'd0, 2'd0, 17'h00000, 10'h000, 1'b0, 32'h00000000}; // NOP
    tbl[4]  = '{3'd4, 2'd3, 2'd1, 17'h00000, 10'h3FF, 1'b0, 32'h0001FFEC}; // WR
    tbl[5]  = '{3'd5, 2'd2, 2'd3, 17'h1FFFF, 10'h3FF, 1'b1, 32'h0000005D}; // REF ignores fields
    tbl[6]  = '{3'd6, 2'd1, 2'd1, 17'h12345, 10'h155, 1'b1, 32'h0000002E}; // ZQ
    tbl[7]  = '{3'd7, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, 1'b1, 32'h00000000}; // type 7 -> NOP
    tbl[8]  = '{3'd1, 2'd2, 2'd1, 17'h1FFFF, 10'h3FF, 1'b0, 32'h00000049}; // PRE single
    tbl[9]  = '{3'd2, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, 1'b1, 32'h00FFFFFA}; // ACT max row
    tbl[10] = '{3'd3, 2'd1, 2'd0, 17'h1FFFF, 10'h155, 1'b1, 32'h0000AAA3}; // RD ignores row
    wa = {16{32'hA5A5_0001}};
    wb = {16{32'h5A5A_0002}};
    wt = {16{32'hC0DE_0003}};

    rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_bg = '0; cmd_bank = '0;
    cmd_row = '0; cmd_col = '0; cmd_pall = 1'b0; cmd_wdata = '0; flush = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset cmd_ready", cmd_ready, 1'b1);
    check_word("reset out_data", out_data, '0);

    // Single-command encodings, each sealed by flush
    for (int i = 0; i < 11; i++) begin
      send_cmd(tbl[i].typ, tbl[i].bg, tbl[i].bank, tbl[i].row, tbl[i].col, tbl[i].pall, wt, waited);
      pulse_flush();
      exp_q.push_back(mk_word(tbl[i].exp_slot, 32'h0, 32'h0, 32'h0,
                              (tbl[i].typ == 3'd4) ? wt : '0));
      expect_words($sformatf("table[%0d]", i));
    end

    // Four commands fill one word
    send_cmd(3'd2, 2'd1, 2'd2, 17'h1ABCD, 10'h0, 1'b0, wt, waited);
    send_cmd(3'd3, 2'd0, 2'd0, 17'h0, 10'h3F, 1'b0, wt, waited);
    send_cmd(3'd1, 2'd0, 2'd0, 17'h0, 10'h0, 1'b1, wt, waited);
    send_cmd(3'd0, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, wt, waited);
    exp_q.push_back(mk_word(32'h00D5E6B2, 32'h00001F83, 32'h00000081, 32'h0, '0));
    expect_words("full word");
    expect_no_word("full word extra", 30);

    // Back-to-back WRs: second seals the first without stalling
    send_cmd(3'd4, 2'd0, 2'd0, 17'h0, 10'd1, 1'b0, wa, waited);
    check_int("wr1 wait", waited, 1);
    send_cmd(3'd4, 2'd0, 2'd0, 17'h0, 10'd2, 1'b0, wb, waited);
    check_int("wr2 no stall", waited, 1);
    exp_q.push_back(mk_word(32'h00000084, 32'h0, 32'h0, 32'h0, wa));
    exp_q.push_back(mk_word(32'h00000104, 32'h0, 32'h0, 32'h0, wb));
    expect_words("wr conflict");

    // Lone ACT sealed by timeout
    step(); step();
    rise_cyc = 0;
    send_cmd(3'd2, 2'd0, 2'd0, 17'h5, 10'h0, 1'b0, wt, waited);
    e_edge = cyc;
    check_bit("timeout busy", busy, 1'b1);
    for (int i = 0; i < 60 && rise_cyc <= e_edge; i++) step();
    check_int("timeout latency", rise_cyc - e_edge, 17);
    exp_q.push_back(mk_word(32'h00000282, 32'h0, 32'h0, 32'h0, '0));
    expect_words("timeout word");

    // Backpressure: 8 accepted, 9th stalls, held word stable
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_cmd(3'd3, 2'd0, 2'd0, 17'h0, 10'(i), 1'b0, wt, waited);
    w1 = mk_word(32'h00000083, 32'h00000103, 32'h00000183, 32'h00000203, '0);
    cmd_valid = 1'b1; cmd_type = 3'd3; cmd_bg = '0; cmd_bank = '0; cmd_col = 10'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_bit("bp 9th stalled", cmd_ready, 1'b0);
      check_word("bp out_data held", out_data, w1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_bit("bp release ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    exp_q.push_back(w1);
    exp_q.push_back(mk_word(32'h00000283, 32'h00000303, 32'h00000383, 32'h00000403, '0));
    exp_q.push_back(mk_word(32'h00000483, 32'h0, 32'h0, 32'h0, '0));
    expect_words("bp order");

    // Flush with empty accumulator emits nothing
    pulse_flush();
    expect_no_word("empty flush", 25);
    check_bit("empty flush valid", out_valid, 1'b0);

    // Flush after two commands
    send_cmd(3'd2, 2'd1, 2'd2, 17'h1ABCD, 10'h0, 1'b0, wt, waited);
    send_cmd(3'd3, 2'd0, 2'd0, 17'h0, 10'h3F, 1'b0, wt, waited);
    pulse_flush();
    exp_q.push_back(mk_word(32'h00D5E6B2, 32'h00001F83, 32'h0, 32'h0, '0));
    expect_words("partial flush");

    // Reset with pending output word and cnt=3
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send_cmd(3'd3, 2'd0, 2'd0, 17'h0, 10'(i), 1'b0, wt, waited);
    check_bit("pre-reset valid", out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_bit("mid reset out_valid", out_valid, 1'b0);
    check_bit("mid reset busy", busy, 1'b0);
    out_ready = 1'b1;
    got_q.delete();
    send_cmd(3'd2, 2'd0, 2'd1, 17'h3, 10'h0, 1'b0, wt, waited);
    pulse_flush();
    exp_q.push_back(mk_word(32'h0000018A, 32'h0, 32'h0, 32'h0, '0));
    expect_words("post reset slot0");
    expect_no_word("final extra", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

endmodule
